// File: rtl/data_mem_pipeline_if.sv
// Bus between the MEM stage and the data memory.
// The MEM stage drives the request side; the memory returns load data, the stall and the misalignment flag.
interface data_mem_pipeline_if;
    logic        memreadm;
    logic        memwritem;
    logic [31:0] aluoutm;
    logic [31:0] writedatam;
    logic [31:0] readdatam;
    logic        memready;
    logic        addr_err;

    modport master (
        output memreadm, memwritem, aluoutm, writedatam,
        input  readdatam, memready, addr_err
    );

    modport slave (
        input  memreadm, memwritem, aluoutm, writedatam,
        output readdatam, memready, addr_err
    );
endinterface

// File: rtl/data_mem_pipeline.sv
// Word-addressed MEM-stage data memory with a configurable access latency.
// While an access is in flight, memready is held low so the pipeline stalls.
module data_mem_pipeline #(
    parameter int DEPTH = 256,
    parameter int AW    = 8,
    parameter int LAT   = 3
) (
    input logic                clk,
    input logic                reset,
    data_mem_pipeline_if.slave bus
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    logic [31:0]   mem [DEPTH];
    logic          req;
    logic          aligned;
    logic          is_store;
    logic [AW-1:0] idx;
    logic          unused_addr;

    assign req         = bus.memreadm | bus.memwritem;
    assign aligned     = (bus.aluoutm[1:0] == 2'b00);
    assign is_store    = bus.memwritem;
    assign idx         = bus.aluoutm[AW+1:2];
    assign unused_addr = ^bus.aluoutm[31:AW+2];

    if (LAT == 0) begin : g_comb
        always_ff @(posedge clk) begin
            if (!reset && req && aligned && is_store)
                mem[idx] <= bus.writedatam;
        end

        assign bus.memready  = 1'b1;
        assign bus.addr_err  = req & ~aligned;
        assign bus.readdatam = (bus.memreadm && !is_store && aligned) ? mem[idx] : '0;
    end else begin : g_fsm
        localparam int CW = (LAT < 2) ? 1 : $clog2(LAT + 1);

        state_t        state, next_state;
        logic [CW-1:0] cnt, next_cnt;
        logic [AW-1:0] idx_q;
        logic [31:0]   data_q;
        logic          store_q;
        logic          accept;

        assign accept = (state == IDLE) && req && aligned;

        // memready depends only on state and the live request so the hazard unit sees the stall at once
        always_comb begin
            next_state   = state;
            next_cnt     = cnt;
            bus.memready = 1'b1;
            bus.addr_err = 1'b0;
            case (state)
                IDLE: begin
                    if (req && !aligned) begin
                        bus.addr_err = 1'b1;
                    end else if (req) begin
                        bus.memready = 1'b0;
                        next_cnt     = CW'(LAT - 1);
                        next_state   = (LAT == 1) ? DONE : BUSY;
                    end
                end
                BUSY: begin
                    bus.memready = 1'b0;
                    next_cnt     = cnt - CW'(1);
                    if (cnt == CW'(1))
                        next_state = DONE;
                end
                DONE:    next_state = IDLE;
                default: next_state = IDLE;
            endcase
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                state         <= IDLE;
                cnt           <= '0;
                idx_q         <= '0;
                data_q        <= '0;
                store_q       <= 1'b0;
                bus.readdatam <= '0;
            end else begin
                state <= next_state;
                cnt   <= next_cnt;
                if (accept) begin
                    idx_q   <= idx;
                    data_q  <= bus.writedatam;
                    store_q <= is_store;
                end
                // Load data is captured on the edge entering DONE so it is stable for the whole DONE cycle
                if (state == IDLE && req && !aligned)
                    bus.readdatam <= '0;
                else if (LAT == 1 && accept && !is_store)
                    bus.readdatam <= mem[idx];
                else if (state == BUSY && next_state == DONE && !store_q)
                    bus.readdatam <= mem[idx_q];
            end
        end

        always_ff @(posedge clk) begin
            if (!reset && state == DONE && store_q)
                mem[idx_q] <= data_q;
        end
    end

endmodule

// File: tb/tb_data_mem_pipeline.sv
// Scoreboard bench for data_mem_pipeline: a LAT=3 instance and a LAT=0 instance share one stimulus driver.
// Requests push their expected completion into a queue; the monitor pops it when memready ends the access.
module tb_data_mem_pipeline;

    typedef struct {
        logic        chk_rd;
        logic [31:0] rdata;
        logic        err;
        int          stall;
    } exp_t;

    logic        clk;
    logic        reset;
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        sel0;
    logic        mon_ready;
    logic        mon_err;
    logic [31:0] mon_rdata;

    int   vectors     = 0;
    int   miscompares = 0;
    int   stall_cnt   = 0;
    exp_t exp_q[$];

    data_mem_pipeline_if bus3();
    data_mem_pipeline_if bus0();

    data_mem_pipeline #(.DEPTH(256), .AW(8), .LAT(3)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus3)
    );

    data_mem_pipeline #(.DEPTH(256), .AW(8), .LAT(0)) dut0 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus0)
    );

    assign bus3.memreadm   = rd & ~sel0;
    assign bus3.memwritem  = wr & ~sel0;
    assign bus3.aluoutm    = addr;
    assign bus3.writedatam = wdata;
    assign bus0.memreadm   = rd & sel0;
    assign bus0.memwritem  = wr & sel0;
    assign bus0.aluoutm    = addr;
    assign bus0.writedatam = wdata;

    assign mon_ready = sel0 ? bus0.memready  : bus3.memready;
    assign mon_err   = sel0 ? bus0.addr_err  : bus3.addr_err;
    assign mon_rdata = sel0 ? bus0.readdatam : bus3.readdatam;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    // Called just after a rising edge; holds the request until the edge that ends the access
    task automatic applyStimulus(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d,
                                 input logic chk, input logic [31:0] exp_rd, input logic exp_err,
                                 input int exp_stall);
        exp_t e;
        logic done;
        e.chk_rd = chk;
        e.rdata  = exp_rd;
        e.err    = exp_err;
        e.stall  = exp_stall;
        exp_q.push_back(e);
        rd    = r;
        wr    = w;
        addr  = a;
        wdata = d;
        done  = 1'b0;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            done = mon_ready;
            @(posedge clk);
            #1;
        end
        rd = 1'b0;
        wr = 1'b0;
        if (!done) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL access_timeout: addr 0x%08h never completed, memready stuck at 0", a);
        end
    endtask

    always @(negedge clk) begin
        if (reset) begin
            stall_cnt = 0;
        end else if (rd || wr) begin
            if (!mon_ready) begin
                stall_cnt++;
            end else begin
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("[TB] FAIL unexpected_completion: got completion at addr 0x%08h, expected none", addr);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    checkOutput("stall_cycles", 32'(stall_cnt), 32'(e.stall));
                    checkOutput("addr_err", {31'b0, mon_err}, {31'b0, e.err});
                    if (e.chk_rd)
                        checkOutput("readdatam", mon_rdata, e.rdata);
                end
                stall_cnt = 0;
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset = 1'b1;
        rd    = 1'b0;
        wr    = 1'b0;
        addr  = '0;
        wdata = '0;
        sel0  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        checkOutput("reset_memready", {31'b0, mon_ready}, 32'd1);
        checkOutput("reset_readdatam", mon_rdata, 32'h0);
        checkOutput("reset_addr_err", {31'b0, mon_err}, 32'd0);
        @(posedge clk);
        #1;

        $display("[TB] LAT=3 load/store sequences");
        applyStimulus(1'b0, 1'b1, 32'h20, 32'h12345678, 1'b0, 32'h0, 1'b0, 3);
        applyStimulus(1'b1, 1'b0, 32'h20, 32'h0, 1'b1, 32'h12345678, 1'b0, 3);
        applyStimulus(1'b0, 1'b1, 32'h40, 32'hA5A5A5A5, 1'b0, 32'h0, 1'b0, 3);
        applyStimulus(1'b1, 1'b0, 32'h40, 32'h0, 1'b1, 32'hA5A5A5A5, 1'b0, 3);

        applyStimulus(1'b0, 1'b1, 32'h42, 32'hFFFFFFFF, 1'b0, 32'h0, 1'b1, 0);
        @(negedge clk);
        checkOutput("misalign_clears_rdata", mon_rdata, 32'h0);
        checkOutput("misalign_err_one_cycle", {31'b0, mon_err}, 32'd0);
        @(posedge clk);
        #1;
        applyStimulus(1'b1, 1'b0, 32'h40, 32'h0, 1'b1, 32'hA5A5A5A5, 1'b0, 3);

        $display("[TB] LAT=3 reset during a store");
        applyStimulus(1'b0, 1'b1, 32'h8, 32'hCAFE0008, 1'b0, 32'h0, 1'b0, 3);
        applyStimulus(1'b1, 1'b0, 32'h8, 32'h0, 1'b1, 32'hCAFE0008, 1'b0, 3);
        wr    = 1'b1;
        addr  = 32'h8;
        wdata = 32'h1;
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        wr    = 1'b0;
        @(negedge clk);
        checkOutput("rst_mid_memready", {31'b0, mon_ready}, 32'd1);
        checkOutput("rst_mid_readdatam", mon_rdata, 32'h0);
        checkOutput("rst_mid_addr_err", {31'b0, mon_err}, 32'd0);
        @(posedge clk);
        #1;
        applyStimulus(1'b1, 1'b0, 32'h8, 32'h0, 1'b1, 32'hCAFE0008, 1'b0, 3);

        $display("[TB] LAT=3 address wrap and store priority");
        applyStimulus(1'b0, 1'b1, 32'h404, 32'h77, 1'b0, 32'h0, 1'b0, 3);
        applyStimulus(1'b1, 1'b0, 32'h004, 32'h0, 1'b1, 32'h77, 1'b0, 3);
        applyStimulus(1'b1, 1'b1, 32'h30, 32'h99, 1'b1, 32'h77, 1'b0, 3);
        applyStimulus(1'b1, 1'b0, 32'h30, 32'h0, 1'b1, 32'h99, 1'b0, 3);
        applyStimulus(1'b1, 1'b0, 32'h21, 32'h0, 1'b0, 32'h0, 1'b1, 0);
        @(negedge clk);
        checkOutput("idle_memready", {31'b0, mon_ready}, 32'd1);
        @(posedge clk);
        #1;

        $display("[TB] LAT=0 single-cycle accesses");
        sel0 = 1'b1;
        @(negedge clk);
        checkOutput("lat0_idle_memready", {31'b0, mon_ready}, 32'd1);
        @(posedge clk);
        #1;
        applyStimulus(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0, 32'h0, 1'b0, 0);
        applyStimulus(1'b1, 1'b0, 32'h10, 32'h0, 1'b1, 32'hDEADBEEF, 1'b0, 0);
        applyStimulus(1'b0, 1'b1, 32'h12, 32'h11111111, 1'b0, 32'h0, 1'b1, 0);
        applyStimulus(1'b1, 1'b0, 32'h10, 32'h0, 1'b1, 32'hDEADBEEF, 1'b0, 0);

        repeat (2) @(posedge clk);
        checkOutput("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
